// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions for the reverse round-key generator.
// Contents:
//   - word / key / round-key width constants
//   - FSM state encoding (IDLE, FWD, REV)
//   - Rcon table for the AES-256 schedule
//   - GF(2^8) helpers and the S-box affine transforms
package aes_pkg;

  localparam int WORD_W   = 32;
  localparam int KEY_W    = 256;
  localparam int RK_W     = KEY_W / 2;
  localparam int RK_WORDS = RK_W / WORD_W;

  typedef logic [WORD_W-1:0] word_t;

  // FSM state enumeration, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FWD  = 2'd1;
  localparam state_t ST_REV  = 2'd2;

  // AES-256 uses Rcon[0..6]; slot 7 only fills the 3-bit index space
  // and is never selected for an even round.
  localparam logic [7:0] RCON [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                      8'h10, 8'h20, 8'h40, 8'h00};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (= a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int i = 2; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
             ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

endpackage

// File: rtl/key_reverse_256_if.sv
// Bus bundle for key_reverse_256.
//   start/key_in      : load request and cipher key (big-endian words)
//   rk_o/rk_round     : round key presented and its AES round index
//   rk_valid/rk_ready : beat handshake, accepted when both are high
//   busy/done         : activity flag and end-of-sequence pulse
// master = key source / round-key consumer, slave = the generator.
interface key_reverse_256_if #(parameter int KEY_WIDTH = aes_pkg::KEY_W) ();
  logic                   start;
  logic [KEY_WIDTH-1:0]   key_in;
  logic [KEY_WIDTH/2-1:0] rk_o;
  logic                   rk_valid;
  logic                   rk_ready;
  logic [3:0]             rk_round;
  logic                   busy;
  logic                   done;

  modport master (
    output start, key_in, rk_ready,
    input  rk_o, rk_valid, rk_round, busy, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output rk_o, rk_valid, rk_round, busy, done
  );
endinterface

// File: rtl/key_g_word.sv
// Key-schedule core transform T applied to one 32-bit word.
//   word_in  : previous schedule word w[i-1]
//   is_odd   : 1 = SubWord only, 0 = SubWord(RotWord) ^ Rcon
//   rcon     : round constant byte (used only when is_odd = 0)
//   word_out : transformed word
module key_g_word
  import aes_pkg::*;
(
  input  word_t      word_in,
  input  logic       is_odd,
  input  logic [7:0] rcon,
  output word_t      word_out
);

  word_t rot_w;
  word_t sub_w;

  assign rot_w = is_odd ? word_in : {word_in[23:0], word_in[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      subbytes_mix u_sbox (
        .byte_in  (rot_w[8*gi +: 8]),
        .zf       (1'b1),
        .byte_out (sub_w[8*gi +: 8])
      );
    end
  endgenerate

  assign word_out = is_odd ? sub_w : (sub_w ^ {rcon, 24'h000000});

endmodule

// File: rtl/subbytes_mix.sv
// Single-byte AES S-box built from GF(2^8) inversion plus affine maps.
//   byte_in  : input byte
//   zf       : 1 = forward S-box, 0 = inverse S-box
//   byte_out : substituted byte
module subbytes_mix
  import aes_pkg::*;
(
  input  logic [7:0] byte_in,
  input  logic       zf,
  output logic [7:0] byte_out
);

  logic [7:0] pre;
  logic [7:0] inv;

  // Forward: inverse then affine. Inverse: inverse-affine then inverse.
  always_comb begin
    pre      = zf ? byte_in : inv_affine(byte_in);
    inv      = gf_inv(pre);
    byte_out = zf ? fwd_affine(inv) : inv;
  end

endmodule

// File: rtl/key_reverse_256.sv
// AES-256 round-key generator that emits round keys in reverse order
// (14 down to 0) for decryption, holding only an 8-word window.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of key_reverse_256_if
// Flow: IDLE latches the key as rounds 0/1, FWD runs the schedule forward
// to rounds 13/14, REV presents hi and unwinds one round per accepted beat.
module key_reverse_256
  import aes_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  key_reverse_256_if.slave  bus
);

  localparam int RK_WIDTH = KEY_WIDTH / 2;

  state_t     state_reg;
  logic [3:0] step_reg;
  logic [3:0] round_reg;
  logic       valid_reg;
  logic       done_reg;
  word_t      lo_reg [RK_WORDS];
  word_t      hi_reg [RK_WORDS];

  logic [3:0] t_round;
  logic [2:0] rcon_idx;
  word_t      g_in;
  word_t      g_out;
  logic [7:0] g_rcon;
  word_t      fwd_w [RK_WORDS];
  word_t      rev_w [RK_WORDS];

  // One T unit serves both directions: FWD transforms hi's last word for
  // round step_reg, REV transforms lo's last word for round round_reg.
  always_comb begin
    t_round  = (state_reg == ST_REV) ? round_reg : step_reg;
    rcon_idx = t_round[3:1] - 3'd1;
    g_rcon   = RCON[rcon_idx];
    g_in     = (state_reg == ST_REV) ? lo_reg[RK_WORDS-1] : hi_reg[RK_WORDS-1];
  end

  key_g_word u_g (
    .word_in  (g_in),
    .is_odd   (t_round[0]),
    .rcon     (g_rcon),
    .word_out (g_out)
  );

  // Forward words chain through the freshly computed word; reverse words
  // only need the current round, so they have no chain.
  always_comb begin
    fwd_w[0] = lo_reg[0] ^ g_out;
    rev_w[0] = hi_reg[0] ^ g_out;
    for (int k = 1; k < RK_WORDS; k++) begin
      fwd_w[k] = lo_reg[k] ^ fwd_w[k-1];
      rev_w[k] = hi_reg[k] ^ hi_reg[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      step_reg  <= '0;
      round_reg <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      for (int k = 0; k < RK_WORDS; k++) begin
        lo_reg[k] <= '0;
        hi_reg[k] <= '0;
      end
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // done_reg masks a start arriving in the done cycle.
          if (bus.start && !done_reg) begin
            for (int k = 0; k < RK_WORDS; k++) begin
              lo_reg[k] <= bus.key_in[KEY_WIDTH-1-WORD_W*k -: WORD_W];
              hi_reg[k] <= bus.key_in[KEY_WIDTH-1-WORD_W*(k+RK_WORDS) -: WORD_W];
            end
            step_reg  <= 4'd2;
            state_reg <= ST_FWD;
          end
        end
        ST_FWD: begin
          for (int k = 0; k < RK_WORDS; k++) begin
            lo_reg[k] <= hi_reg[k];
            hi_reg[k] <= fwd_w[k];
          end
          if (step_reg == 4'd14) begin
            state_reg <= ST_REV;
            round_reg <= 4'd14;
            valid_reg <= 1'b1;
          end else begin
            step_reg <= step_reg + 4'd1;
          end
        end
        ST_REV: begin
          if (bus.rk_ready) begin
            if (round_reg >= 4'd2) begin
              for (int k = 0; k < RK_WORDS; k++) begin
                hi_reg[k] <= lo_reg[k];
                lo_reg[k] <= rev_w[k];
              end
              round_reg <= round_reg - 4'd1;
            end else if (round_reg == 4'd1) begin
              // Round 0 is already in lo; nothing to compute.
              for (int k = 0; k < RK_WORDS; k++) begin
                hi_reg[k] <= lo_reg[k];
              end
              round_reg <= 4'd0;
            end else begin
              state_reg <= ST_IDLE;
              valid_reg <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < RK_WORDS; gi++) begin : g_rk_out
      assign bus.rk_o[RK_WIDTH-1-WORD_W*gi -: WORD_W] = hi_reg[gi];
    end
  endgenerate

  assign bus.rk_valid = valid_reg;
  assign bus.rk_round = round_reg;
  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_key_reverse_256.sv
// Self-checking bench for key_reverse_256: directed keys, a vector table of
// known round keys, an independent key-expansion model, backpressure,
// ignored starts and mid-run resets.
module tb_key_reverse_256;

  localparam logic [255:0] KEY0 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY1 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    int           key_id;
    int           round;
    logic [127:0] rk;
  } vec_t;

  logic clk;
  logic rst_n;

  key_reverse_256_if bus ();

  key_reverse_256 #(.KEY_WIDTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got    [15];
  logic [127:0] got0   [15];
  logic [127:0] got1   [15];
  vec_t         vecs   [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rk_o"},     bus.rk_o,     '0);
    check({tag, "_rk_valid"}, bus.rk_valid, '0);
    check({tag, "_rk_round"}, bus.rk_round, '0);
    check({tag, "_busy"},     bus.busy,     '0);
    check({tag, "_done"},     bus.done,     '0);
  endtask

  // Shift-and-add product, then reduce modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] mmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // S-box by exhaustive inverse search and per-bit affine transform.
  task automatic build_sbox();
    logic [7:0] c63;
    logic [7:0] inv;
    logic [7:0] s;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (mmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  // Word-by-word AES-256 expansion into exp_rk[0..14].
  task automatic model_expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a falling edge with the DUT idle.
  // mode 0: rk_ready high; 1: 1-5 stall cycles per beat;
  // mode 2: ready high plus start pokes in FWD, REV and the done cycle.
  task automatic run_key(input logic [255:0] key, input int mode, input string tag);
    int   lat;
    int   b;
    int   cyc;
    int   stall;
    logic busy_ok;
    model_expand(key);
    bus.key_in   = key;
    bus.start    = 1'b1;
    bus.rk_ready = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      bus.start  = (mode == 2 && lat == 6);
      bus.key_in = (mode == 2 && lat == 6) ? ~key : key;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end while (bus.rk_valid !== 1'b1 && lat < 40);
    check({tag, "_latency"}, lat, 14);

    b     = 0;
    cyc   = 0;
    stall = (mode == 1) ? int'($urandom_range(5, 1)) : 0;
    while (b < 15 && cyc < 400) begin
      if (bus.rk_valid !== 1'b1) break;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      check($sformatf("%s_rk_o_b%0d", tag, b), bus.rk_o, exp_rk[14-b]);
      check($sformatf("%s_rk_round_b%0d", tag, b), bus.rk_round, 14 - b);
      bus.start = (mode == 2 && b == 7);
      if (stall > 0) begin
        bus.rk_ready = 1'b0;
        stall--;
      end else begin
        bus.rk_ready = 1'b1;
        got[14-b] = bus.rk_o;
        $display("%s beat %0d round %0d rk %h", tag, b, bus.rk_round, bus.rk_o);
        b++;
        stall = (mode == 1) ? int'($urandom_range(5, 1)) : 0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.rk_ready = 1'b0;
    bus.start    = 1'b0;
    check({tag, "_beats"}, b, 15);
    check({tag, "_busy_run"}, busy_ok, 1);

    check({tag, "_done"}, bus.done, 1);
    check({tag, "_valid_off"}, bus.rk_valid, 0);
    bus.start  = (mode == 2);
    bus.key_in = ~key;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_done_pulse"}, bus.done, 0);
    repeat (3) @(negedge clk);
    check({tag, "_idle"}, {bus.busy, bus.rk_valid}, 0);
  endtask

  initial begin
    int cyc;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;

    vecs[0] = '{0, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vecs[1] = '{0,  0, 128'h000102030405060708090a0b0c0d0e0f};
    vecs[2] = '{0,  1, 128'h101112131415161718191a1b1c1d1e1f};
    vecs[3] = '{1, 14, 128'hfe4890d1e6188d0b046df344706c631e};
    vecs[4] = '{1,  0, 128'h603deb1015ca71be2b73aef0857d7781};
    vecs[5] = '{1,  1, 128'h1f352c073b6108d72d9810a30914dff4};

    build_sbox();

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    run_key(KEY0, 0, "k0");
    got0 = got;
    run_key(KEY1, 0, "k1");
    got1 = got;

    for (int i = 0; i < 6; i++) begin
      check($sformatf("table_k%0d_r%0d", vecs[i].key_id, vecs[i].round),
            (vecs[i].key_id == 0) ? got0[vecs[i].round] : got1[vecs[i].round],
            vecs[i].rk);
      $display("table k%0d round %0d rk %h", vecs[i].key_id, vecs[i].round, vecs[i].rk);
    end

    run_key(KEY0, 1, "k0_stall");
    run_key(KEY0, 2, "k0_poke");

    // Reset in the sixth FWD cycle.
    bus.key_in = KEY1;
    bus.start  = 1'b1;
    repeat (6) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("fwd6_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("rst_fwd");
    @(negedge clk);
    rst_n = 1'b1;
    run_key(KEY0, 0, "after_rst_fwd");

    // Reset while beat 7 (round 7) is presented.
    model_expand(KEY1);
    bus.key_in = KEY1;
    bus.start  = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end while (bus.rk_valid !== 1'b1 && cyc < 40);
    bus.rk_ready = 1'b1;
    while (bus.rk_round !== 4'd7 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    check("rev_b7_round", bus.rk_round, 7);
    check("rev_b7_rk_o", bus.rk_o, exp_rk[7]);
    rst_n = 1'b0;
    #1;
    check_zero("rst_rev");
    bus.rk_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_key(KEY1, 0, "after_rst_rev");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/key_reverse_256.md
KEY_REVERSE_256 -- requirements
Module: key_reverse_256

Interface
REQ-001 The block SHALL have one parameter, KEY_WIDTH, default 256, giving the cipher key width in bits; the round-key width is KEY_WIDTH/2.
REQ-002 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  Reset; asynchronous and active-low.
REQ-004 start  input  1  Load request; sampled only in IDLE.
REQ-005 key_in  input  256  Cipher key, big-endian word order (w0 = key_in[255:224]); sampled when start is accepted.
REQ-006 rk_o  output  128  Round key being presented; word order {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-007 rk_valid  output  1  rk_o and rk_round are valid.
REQ-008 rk_ready  input  1  Consumer accepts the beat when rk_valid and rk_ready are both high.
REQ-009 rk_round  output  4  AES round index of rk_o.
REQ-010 busy  output  1  High in every state except IDLE.
REQ-011 done  output  1  One-cycle pulse after round 0 is accepted.

Function
REQ-012 The FSM SHALL have three states: IDLE, FWD and REV.
REQ-013 IDLE SHALL latch key_in into an 8-word window {lo = round 0, hi = round 1} when start is high, and move to FWD with a step counter r = 2.
REQ-014 FWD SHALL compute one round key (4 words) per cycle, for r = 2..14, and then shift: lo <= hi, hi <= new.
- Even r: w[4r] = w[4r-8] ^ SubWord(RotWord(w[4r-1])) ^ Rcon[r/2-1].
- Odd r: w[4r] = w[4r-8] ^ SubWord(w[4r-1]).
- Remaining words: w[4r+k] = w[4r+k-8] ^ w[4r+k-1].
REQ-015 After 13 FWD cycles the window SHALL hold rounds 13/14, and the FSM SHALL enter REV with rk_round = 14.
- rk_valid SHALL first go high exactly 14 cycles after the cycle in which start was sampled.
REQ-016 In REV, rk_o SHALL equal hi and rk_valid SHALL be 1.
REQ-017 On each accepted beat with rk_round = r ≥ 2, the block SHALL apply the inverse recurrence and decrement rk_round.
- Previous round: w[4r-8+k] = w[4r+k] ^ (k==0 ? T(w[4r-1]) : w[4r+k-1]).
- T is the even or odd function of REQ-014, selected by the parity of r; w[4r-1] is lo's last word.
- Window update: hi <= lo, lo <= computed words.
REQ-018 On the beat with rk_round = 1, the block SHALL do hi <= lo only, with no computation.
- On the beat with rk_round = 0, the FSM SHALL return to IDLE, deassert rk_valid and pulse done.
REQ-019 Exactly 15 beats SHALL be emitted, in order 14, 13, ..., 0.
REQ-020 While rk_valid && !rk_ready, rk_o and rk_round SHALL hold stable; backpressure of any length SHALL be tolerated.
REQ-021 start SHALL be ignored while busy, and a start in the same cycle that done is pulsed SHALL be ignored.
REQ-022 The Rcon table SHALL be {01,02,04,08,10,20,40}; only indices 0..6 are reachable.
REQ-023 All XOR operations SHALL be 32-bit bitwise, with no carry and no width growth.

Reset
REQ-024 Asserting rst_n low at any time, including mid-FWD or mid-REV, SHALL force IDLE, clear the window to zero, and drive rk_o = 0, rk_valid = 0, rk_round = 0, busy = 0 and done = 0.
REQ-025 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Structure
REQ-026 A shared package aes_pkg SHALL hold:
- the Rcon table;
- the FSM state enumeration;
- the word, round-key and key width constants.
REQ-027 The block SHALL contain one sub-module, key_g_word, which:
- takes a 32-bit word, an is_odd flag and an 8-bit rcon;
- applies RotWord, four forward SubBytes_mix instances (ZF tied high) and the Rcon XOR;
- is shared by FWD and REV through an input mux.
REQ-028 No combinational path SHALL exist from rk_ready to rk_o or rk_valid.

Verification
REQ-029 Key 000102...1f, rk_ready held high:
- beat 0 = 24fc79ccbf0979e9371ac23c6d68de36 with rk_round 14;
- beat 14 = 000102030405060708090a0b0c0d0e0f with rk_round 0;
- done high the cycle after beat 14.
REQ-030 Key 603deb10...0914dff4: first beat = fe4890d1e6188d0b046df344706c631e; all 15 beats SHALL match a software model.
REQ-031 Random rk_ready backpressure (1-5 stall cycles per beat): rk_o and rk_round stable during each stall; sequence identical to REQ-029.
REQ-032 start pulsed during FWD and during REV: no restart, output sequence unchanged.
REQ-033 rst_n asserted at FWD cycle 6 and again at REV beat 7: all outputs 0 immediately; a fresh start then produces the full correct sequence, first beat at cycle 14.
REQ-034 Latency check: rk_valid rises exactly 14 cycles after start is sampled; busy stays high from the cycle after start until the cycle after done.
